ef_sha256_apb_msgq: RTL and testbench

APB front-end for the SHA-256 core that adds a parametrised-depth message-word FIFO between software writes and the core's 512-bit block interface. Software streams 32-bit words into a DATA register without polling the core. The block assembles every 16 queued words into one block, launches the core, captures the 256-bit digest, and raises a maskable interrupt. It replaces a direct register-mapped block interface and sits between the APB fabric and `sha256_core`.

---
 rtl/ef_sha256_msgq_pkg.sv | 18 +
 rtl/ef_sha256_apb_msgq_if.sv | 13 +
 rtl/ef_sha256_msgq_fifo.sv | 42 ++++
 rtl/ef_sha256_apb_msgq.sv | 114 +++++++++++
 tb/tb_ef_sha256_apb_msgq.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ef_sha256_msgq_pkg.sv
// ef_sha256_msgq_pkg: register offsets, IRQ bit indices, FSM states and block size
// for the SHA-256 APB message-queue front-end.
package ef_sha256_msgq_pkg;
   localparam logic [15:0] A_DATA   = 16'h0000;
   localparam logic [15:0] A_CTRL   = 16'h0004;
   localparam logic [15:0] A_STATUS = 16'h0008;
   localparam logic [15:0] A_BLKCNT = 16'h000C;
   localparam logic [15:0] A_DIGEST = 16'h0010;
   localparam logic [15:0] A_DIGEND = 16'h0030;
   localparam logic [15:0] A_IM     = 16'hFF00;
   localparam logic [15:0] A_MIS    = 16'hFF04;
   localparam logic [15:0] A_RIS    = 16'hFF08;
   localparam logic [15:0] A_IC     = 16'hFF0C;
   localparam int IRQ_DONE  = 0;
   localparam int IRQ_OVF   = 1;
   localparam int BLK_WORDS = 16;
   typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} state_e;
endpackage

// File: rtl/ef_sha256_apb_msgq_if.sv
// ef_sha256_apb_msgq_if: APB3 bus bundle between the fabric (master) and the
// message-queue front-end (slave).
interface ef_sha256_apb_msgq_if;
   logic [15:0] PADDR;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;
   modport master (output PADDR, PSEL, PENABLE, PWRITE, PWDATA, input PRDATA, PREADY);
   modport slave (input PADDR, PSEL, PENABLE, PWRITE, PWDATA, output PRDATA, PREADY);
endinterface

// File: rtl/ef_sha256_msgq_fifo.sv
// ef_sha256_msgq_fifo: synchronous first-word-fall-through FIFO with level output
// and a synchronous flush; callers guarantee no push when full / pop when empty.
module ef_sha256_msgq_fifo #(
   parameter int DEPTH = 32,
   parameter int WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, rd_q;
   logic [AW:0]      lvl_q;
   always_ff @(posedge clk)
      if (push) mem_q[wr_q] <= wdata;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         lvl_q <= '0;
      end else if (flush) begin
         wr_q  <= '0;
         rd_q  <= '0;
         lvl_q <= '0;
      end else begin
         if (push) wr_q <= wr_q + 1'b1;
         if (pop) rd_q <= rd_q + 1'b1;
         lvl_q <= lvl_q + (AW+1)'(push) - (AW+1)'(pop);
      end
   assign rdata = mem_q[rd_q];
   assign full  = lvl_q == (AW+1)'(DEPTH);
   assign empty = lvl_q == '0;
   assign level = lvl_q;
endmodule

// File: rtl/ef_sha256_apb_msgq.sv
// ef_sha256_apb_msgq: APB message-word FIFO feeding sha256_core 512-bit blocks,
// digest capture and maskable DONE/OVF interrupts. Option: EF_SHA256_MSGQ_BLKCNT_EN.
module ef_sha256_apb_msgq
   import ef_sha256_msgq_pkg::*;
#(
   parameter int FIFO_DEPTH = 32,
   parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   ef_sha256_apb_msgq_if.slave   apb,
   output logic                  IRQ,
   output logic [511:0]          core_block,
   output logic                  core_init,
   output logic                  core_start,
   input  logic                  core_ready,
   input  logic                  core_digest_valid,
   input  logic [255:0]          core_digest
);
   state_e           state_q, state_d;
   logic [3:0]       cnt_q;
   logic [511:0]     blk_q;
   logic [255:0]     dig_q;
   logic             init_q, dv_q;
   logic [1:0]       im_q, ris_q, ris_set;
   logic [31:0]      rd, fifo_rdata, blkcnt_q;
   logic [LVL_W-1:0] level;
   logic [15:0]      addr;
   logic [2:0]       di;
   logic             full, empty, wr, data_wr, ctrl_wr, push, pop, flush;
   logic             unused_ok;
   assign addr    = {apb.PADDR[15:2], 2'b00};
   assign wr      = apb.PSEL & apb.PENABLE & apb.PWRITE;
   assign data_wr = wr && addr == A_DATA;
   assign ctrl_wr = wr && addr == A_CTRL;
   assign push    = data_wr & ~full;
   assign pop     = state_q == LOAD;
   assign flush   = ctrl_wr && apb.PWDATA[1] && state_q == IDLE;
   assign unused_ok = &{1'b0, apb.PADDR[1:0], apb.PWDATA[31:2]};
   ef_sha256_msgq_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
      .clk(PCLK), .rst_n(PRESETn), .push(push), .pop(pop), .flush(flush),
      .wdata(apb.PWDATA), .rdata(fifo_rdata), .full(full), .empty(empty), .level(level)
   );
   always_comb begin
      state_d    = state_q;
      core_start = 1'b0;
      core_init  = 1'b0;
      case (state_q)
         IDLE:    if (level >= LVL_W'(BLK_WORDS) && core_ready) state_d = LOAD;
         LOAD:    if (cnt_q == 4'hF) state_d = START;
         START: begin
            state_d    = WAIT;
            core_start = 1'b1;
            core_init  = init_q;
         end
         default: if (core_digest_valid) state_d = IDLE;
      endcase
   end
   always_comb begin
      ris_set           = '0;
      ris_set[IRQ_DONE] = state_q == WAIT && core_digest_valid;
      ris_set[IRQ_OVF]  = data_wr & full;
   end
   always_ff @(posedge PCLK or negedge PRESETn)
      if (!PRESETn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         blk_q   <= '0;
         dig_q   <= '0;
         init_q  <= 1'b0;
         dv_q    <= 1'b0;
         im_q    <= '0;
         ris_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= pop ? cnt_q + 4'd1 : 4'd0;
         if (pop) blk_q <= {blk_q[479:0], fifo_rdata};
         if (state_q == START) init_q <= 1'b0;
         else if (ctrl_wr) init_q <= apb.PWDATA[0];
         if (state_q == START) dv_q <= 1'b0;
         else if (ris_set[IRQ_DONE]) begin
            dv_q  <= 1'b1;
            dig_q <= core_digest;
         end
         if (wr && addr == A_IM) im_q <= apb.PWDATA[1:0];
         ris_q <= (ris_q & ~((wr && addr == A_IC) ? apb.PWDATA[1:0] : 2'b00)) | ris_set;
      end
`ifdef EF_SHA256_MSGQ_BLKCNT_EN
   always_ff @(posedge PCLK or negedge PRESETn)
      if (!PRESETn) blkcnt_q <= '0;
      else if (ctrl_wr && apb.PWDATA[0]) blkcnt_q <= '0;
      else if (core_start) blkcnt_q <= blkcnt_q + 32'd1;
`else
   assign blkcnt_q = '0;
`endif
   // DIGEST0 (H0) sits in the top word of the captured digest
   assign di = 3'(addr[5:2] - 4'd4);
   always_comb begin
      rd = '0;
      case (addr)
         A_CTRL:   rd = {31'd0, init_q};
         A_STATUS: rd = 32'(level) | {12'd0, dv_q, state_q != IDLE, full, empty, 16'd0};
         A_BLKCNT: rd = blkcnt_q;
         A_IM:     rd = {30'd0, im_q};
         A_MIS:    rd = {30'd0, ris_q & im_q};
         A_RIS:    rd = {30'd0, ris_q};
         default:  rd = (addr >= A_DIGEST && addr < A_DIGEND) ? dig_q[{~di, 5'd0} +: 32] : '0;
      endcase
   end
   assign apb.PRDATA = (apb.PSEL & apb.PENABLE & ~apb.PWRITE) ? rd : '0;
   assign apb.PREADY = 1'b1;
   assign IRQ        = |(ris_q & im_q);
   assign core_block = blk_q;
endmodule

// File: tb/tb_ef_sha256_apb_msgq.sv
// tb_ef_sha256_apb_msgq: register table, directed corner sequences and random
// word streams checked against a queue model and a behavioural core.
module tb_ef_sha256_apb_msgq;
   import ef_sha256_msgq_pkg::*;
   localparam logic [255:0] ABC = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   typedef struct {
      logic [15:0] a;
      bit          w;
      logic [31:0] d;
      logic [31:0] e;
      string       n;
   } vec_t;
   logic clk = 1'b0, rst_n = 1'b0;
   logic irq, core_init, core_start, core_ready = 1'b0, core_dv = 1'b0;
   logic [511:0] core_block, last_block, eb;
   logic [255:0] core_digest = '0, last_dig = '0, dig;
   logic [31:0]  q[$];
   logic [31:0]  v, w0;
   logic         init_seen = 1'b0;
   bit           use_abc = 1'b0;
   int n_tests = 0, n_fail = 0, cyc = 0, start_cnt = 0, start_cyc = 0, acc_cyc = 0, s;
   vec_t tbl[15];
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   ef_sha256_apb_msgq_if apb();
   ef_sha256_apb_msgq dut (
      .PCLK(clk), .PRESETn(rst_n), .apb(apb), .IRQ(irq), .core_block(core_block),
      .core_init(core_init), .core_start(core_start), .core_ready(core_ready),
      .core_digest_valid(core_dv), .core_digest(core_digest)
   );
   task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask
   task automatic apb_wr(input logic [15:0] a, input logic [31:0] d);
      @(negedge clk);
      apb.PADDR = a; apb.PWDATA = d; apb.PWRITE = 1'b1; apb.PSEL = 1'b1; apb.PENABLE = 1'b0;
      @(negedge clk);
      apb.PENABLE = 1'b1;
      @(negedge clk);
      apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
      acc_cyc = cyc;
   endtask
   task automatic apb_rd(input logic [15:0] a, output logic [31:0] d);
      @(negedge clk);
      apb.PADDR = a; apb.PWRITE = 1'b0; apb.PSEL = 1'b1; apb.PENABLE = 1'b0;
      @(negedge clk);
      apb.PENABLE = 1'b1;
      #1 d = apb.PRDATA;
      @(negedge clk);
      apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
   endtask
   task automatic rd_chk(input string n, input logic [15:0] a, input logic [31:0] e);
      logic [31:0] r;
      apb_rd(a, r);
      check(n, r, e);
   endtask
   // the model holds every accepted word until its block is launched
   task automatic push(input logic [31:0] wd);
      if (q.size() < 32) q.push_back(wd);
      apb_wr(A_DATA, wd);
   endtask
   task automatic wait_idle(input string n);
      logic [31:0] r;
      bit ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         apb_rd(A_STATUS, r);
         ok = !r[18] && r[5:0] < 6'd16;
      end
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: idle not reached, status %h", n, r);
      end
   endtask
   task automatic wait_start(input string n, input int prev);
      int k = 0;
      while (start_cnt == prev && k < 200) begin
         @(negedge clk);
         k++;
      end
      n_tests++;
      if (start_cnt == prev) begin
         n_fail++;
         $display("FAIL %s: no start pulse in 200 cycles", n);
      end
   endtask
   // behavioural core: on each launch compare the block with the next 16 model words
   initial forever begin
      @(negedge clk);
      if (core_start) begin
         start_cnt++;
         start_cyc  = cyc;
         init_seen  = core_init;
         last_block = core_block;
         n_tests++;
         if (q.size() < 16) begin
            n_fail++;
            $display("FAIL blk_avail: block launched with %0d model words", q.size());
         end else begin
            eb = '0;
            for (int i = 0; i < 16; i++) eb = {eb[479:0], q.pop_front()};
            if (core_block !== eb) begin
               n_fail++;
               $display("FAIL blk_data: got %h expected %h", core_block, eb);
            end
         end
         if (use_abc) dig = ABC;
         else for (int i = 0; i < 8; i++) dig[i*32 +: 32] = $urandom;
         repeat (3) @(negedge clk);
         core_digest = dig;
         last_dig    = dig;
         core_dv     = 1'b1;
         @(negedge clk);
         core_dv = 1'b0;
      end
   end
   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end
   initial begin
      apb.PADDR = '0; apb.PWDATA = '0; apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
      tbl[0]  = '{A_STATUS, 1'b0, 32'h0, 32'h0001_0000, "st_rst"};
      tbl[1]  = '{A_CTRL,   1'b0, 32'h0, 32'h0, "ctrl_rst"};
      tbl[2]  = '{A_IM,     1'b0, 32'h0, 32'h0, "im_rst"};
      tbl[3]  = '{A_RIS,    1'b0, 32'h0, 32'h0, "ris_rst"};
      tbl[4]  = '{A_DIGEST, 1'b0, 32'h0, 32'h0, "dig0_rst"};
      tbl[5]  = '{A_BLKCNT, 1'b0, 32'h0, 32'h0, "blkcnt_rst"};
      tbl[6]  = '{A_IM,     1'b1, 32'h3, 32'h0, "im_wr"};
      tbl[7]  = '{A_IM,     1'b0, 32'h0, 32'h3, "im_rd"};
      tbl[8]  = '{A_CTRL,   1'b1, 32'h1, 32'h0, "ctrl_wr"};
      tbl[9]  = '{A_CTRL,   1'b0, 32'h0, 32'h1, "ctrl_init"};
      tbl[10] = '{A_CTRL,   1'b1, 32'h2, 32'h0, "ctrl_flush"};
      tbl[11] = '{A_CTRL,   1'b0, 32'h0, 32'h0, "ctrl_flush_rd0"};
      tbl[12] = '{16'h0040, 1'b0, 32'h0, 32'h0, "unmapped"};
      tbl[13] = '{A_MIS,    1'b0, 32'h0, 32'h0, "mis_rst"};
      tbl[14] = '{A_IM,     1'b1, 32'h0, 32'h0, "im_clr"};
      repeat (3) @(negedge clk);
      check("rst_irq", {31'd0, irq}, 32'h0);
      check("rst_start", {31'd0, core_start}, 32'h0);
      check("rst_init", {31'd0, core_init}, 32'h0);
      check("rst_block", core_block[511:480] | core_block[31:0], 32'h0);
      check("rst_prdata", apb.PRDATA, 32'h0);
      rst_n = 1'b1;
      for (int i = 0; i < 15; i++) begin
         if (tbl[i].w) apb_wr(tbl[i].a, tbl[i].d);
         else rd_chk(tbl[i].n, tbl[i].a, tbl[i].e);
      end
      // "abc" single-block message
      apb_wr(A_IM, 32'h1);
      apb_wr(A_CTRL, 32'h1);
      core_ready = 1'b1;
      use_abc = 1'b1;
      s = start_cnt;
      push(32'h6162_6380);
      for (int i = 0; i < 14; i++) push(32'h0);
      push(32'h0000_0018);
      wait_start("abc_start", s);
      check("abc_init", {31'd0, init_seen}, 32'h1);
      wait_idle("abc_idle");
      use_abc = 1'b0;
      rd_chk("abc_dig0", A_DIGEST, 32'hBA78_16BF);
      rd_chk("abc_dig7", A_DIGEST + 16'h1C, 32'hF200_15AD);
      check("abc_irq", {31'd0, irq}, 32'h1);
      rd_chk("abc_status", A_STATUS, 32'h0009_0000);
      rd_chk("abc_init_clr", A_CTRL, 32'h0);
      apb_wr(A_IC, 32'h1);
      check("abc_irq_clr", {31'd0, irq}, 32'h0);
      // fill to full with the core stalled, then overflow once
      core_ready = 1'b0;
      s = start_cnt;
      for (int i = 0; i < 32; i++) push($urandom);
      rd_chk("full_status", A_STATUS, 32'h000A_0020);
      push(32'hDEAD_BEEF);
      rd_chk("ovf_ris", A_RIS, 32'h2);
      rd_chk("ovf_status", A_STATUS, 32'h000A_0020);
      check("ovf_nostart", start_cnt, s);
      core_ready = 1'b1;
      wait_idle("drain_idle");
      check("drain_blocks", start_cnt, s + 2);
      rd_chk("drain_status", A_STATUS, 32'h0009_0000);
      apb_wr(A_IC, 32'h3);
      // launch latency from the 16th accepted word
      s = start_cnt;
      w0 = $urandom;
      push(w0);
      for (int i = 0; i < 15; i++) push($urandom);
      v = acc_cyc;
      wait_start("lat_start", s);
      check("lat_cycles", start_cyc - v, 32'd17);
      check("lat_word0", last_block[511:480], w0);
      wait_idle("lat_idle");
      // flush, then reset in the middle of LOAD
      core_ready = 1'b0;
      for (int i = 0; i < 8; i++) push($urandom);
      apb_wr(A_CTRL, 32'h2);
      q.delete();
      rd_chk("flush_status", A_STATUS, 32'h0009_0000);
      core_ready = 1'b1;
      s = start_cnt;
      for (int i = 0; i < 16; i++) push($urandom);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("rst_load_start", {31'd0, core_start}, 32'h0);
      rst_n = 1'b1;
      q.delete();
      repeat (30) @(negedge clk);
      check("rst_load_nostart", start_cnt, s);
      rd_chk("rst_load_status", A_STATUS, 32'h0001_0000);
      // random word stream with a wandering core_ready
      s = start_cnt;
      for (int i = 0; i < 400; i++) begin
         int r = $urandom_range(0, 9);
         if (r < 6 && q.size() < 32) push($urandom);
         else if (r < 8) begin
            apb_rd(A_STATUS, v);
            if (!v[18]) check("rnd_level", {26'd0, v[5:0]}, q.size());
         end else begin
            core_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
         end
      end
      core_ready = 1'b1;
      wait_idle("rnd_idle");
      apb_rd(A_STATUS, v);
      check("rnd_final_level", {26'd0, v[5:0]}, q.size());
      if (start_cnt > s) rd_chk("rnd_dig0", A_DIGEST, last_dig[255:224]);
      apb_rd(A_RIS, v);
      check("rnd_no_ovf", {31'd0, v[1]}, 32'h0);
`ifdef EF_SHA256_MSGQ_BLKCNT_EN
      apb_wr(A_CTRL, 32'h1);
      rd_chk("blkcnt_clr", A_BLKCNT, 32'h0);
      for (int b = 0; b < 3; b++) begin
         for (int i = 0; i < 16; i++) push($urandom);
         wait_idle("blkcnt_idle");
      end
      rd_chk("blkcnt_3", A_BLKCNT, 32'h3);
      apb_wr(A_CTRL, 32'h1);
      rd_chk("blkcnt_init_clr", A_BLKCNT, 32'h0);
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
